prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream feeder for the CPU core: takes a program image as a byte stream and writes it into the CPU RAM as 64-bit words.
- Once the image is in RAM, it pulses `run` so the CPU state machine leaves idle and begins opcode fetch.
- Owns the RAM write port only while the CPU is halted or idle; the top level muxes it onto the RAM load/addr/d inputs.

Parameters:
- ADDR_W, 16, width of RAM byte address (matches the CPU address bus slice abus[15:0]).
- BASE_ADDR, 0, byte address of the first loaded word.
- MAX_WORDS, 8192, largest word count accepted in the header.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle request to begin a load; ignored unless IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready on a rising edge.
- ram_we  output  1  one-cycle full-word (8-byte) RAM write strobe.
- ram_addr  output  ADDR_W  write byte address.
- ram_wdata  output  64  write data.
- run  output  1  one-cycle pulse to the CPU after a successful load.
- busy  output  1  high in HDR0, HDR1, LOAD and CSUM.
- done  output  1  high in DONE.
- err  output  1  high in ERR.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters and assembly register 0.
- Reset mid-load aborts immediately. No further ram_we or run is produced.
- States: IDLE, HDR0, HDR1, LOAD, CSUM (only with the optional feature), FIRE, DONE, ERR.
- in_ready is 1 only in HDR0, HDR1, LOAD and CSUM. No byte is ever dropped; bytes are consumed only on a handshake.
- IDLE/DONE/ERR + start -> HDR0. Word index k, byte index j and the checksum are cleared, and err/done are cleared.
- HDR0: the byte is the low byte of word count N -> HDR1.
- HDR1: the byte is the high byte of N.
  - N > MAX_WORDS -> ERR.
  - N == 0 -> FIRE (or CSUM if the feature is enabled).
  - Otherwise -> LOAD.
- LOAD: byte j goes to assembly bits [8j+7:8j] (little-endian), then j increments.
  - On the handshake with j==7, the cycle after has ram_we=1, ram_wdata = the assembled word, ram_addr = BASE_ADDR + 8*k (modulo 2^ADDR_W; wrap is not an error). k then increments and j returns to 0.
  - ram_we is registered, so in_ready stays high and back-to-back bytes sustain 1 byte/cycle.
  - After the write for k==N-1, the block goes to FIRE (or CSUM).
- FIRE: run=1 for exactly one cycle -> DONE.
- DONE holds until start or rst. ERR holds until start or rst.
- start while busy is ignored.
- A stalled stream (in_valid low) simply waits; there is no timeout.
- Write count is exactly N; no write is ever issued for a partial word.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every payload byte is kept (header excluded).
  - After the last word, the state is CSUM; one trailing byte is accepted.
  - Match -> FIRE.
  - Mismatch -> ERR, and run is never pulsed. RAM contents already written stay.
  - For N==0 the expected checksum is 0x00.
- Undefined: the CSUM state is absent and there is no trailing byte.

Decomposition:
- Shared package/include `data/loader_d.v`: state encodings (LD_IDLE, LD_HDR0, LD_HDR1, LD_LOAD, LD_CSUM, LD_FIRE, LD_DONE, LD_ERR) and the WORD_BYTES=8 constant.
- One natural sub-module: `byte_packer` (8-byte little-endian shift/assemble with j counter and word_ready strobe).
- The FSM and address counter stay in prog_loader.

Test Plan:
- Start, bytes 02 00, then 16 payload bytes 01..10 back-to-back -> ram_we twice:
  - addr 0x0000, data 0x0807060504030201;
  - addr 0x0008, data 0x100F0E0D0C0B0A09;
  - then run pulses for 1 cycle; done=1.
- Same image with in_valid toggled every other cycle -> identical writes and data; no byte lost; in_ready never drops while busy.
- Header 00 00 -> no ram_we, run pulse 1 cycle after the second header byte's FIRE entry; done=1.
- Header 01 20 (N=8193 > MAX_WORDS) -> err=1, in_ready=0, no ram_we, no run; a later start recovers to HDR0.
- rst asserted after 5 payload bytes -> all outputs 0 next cycle; no ram_we/run afterward. Start after that + full image -> correct writes from addr 0.
- PROG_LOADER_CHECKSUM_EN, N=1, payload 01..08, trailer 0x08 (XOR) -> run pulse. Trailer 0x09 -> err=1, no run, word at 0x0000 written.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings and word geometry.
package prog_loader_pkg;

    localparam int WORD_BYTES = 8;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_HDR0 = 3'd1,
        LD_HDR1 = 3'd2,
        LD_LOAD = 3'd3,
        LD_CSUM = 3'd4,
        LD_FIRE = 3'd5,
        LD_DONE = 3'd6,
        LD_ERR  = 3'd7
    } ld_state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian 8-byte word assembler. Bytes shift in from the top so that after
// seven bytes the holding register carries bytes 0..6 in place; the eighth byte
// is merged combinationally, so the full word and word_ready appear in the same
// cycle as the final byte's handshake.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [63:0] word,
    output logic        word_ready
);

    logic [2:0]  j;
    logic [55:0] sh;

    assign word_ready = en && (j == 3'(WORD_BYTES - 1));
    assign word       = {din, sh};

    // Byte index and shift register; cleared on reset, on a new load, and after each full word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            j  <= 3'd0;
            sh <= 56'd0;
        end else if (en) begin
            j <= j + 3'd1;
            if (j == 3'(WORD_BYTES - 1))
                sh <= 56'd0;
            else
                sh <= {din, sh[55:8]};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte image, writes it to CPU RAM
// as 64-bit words, then pulses run to start the CPU.
// Optional trailing XOR checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [63:0]       ram_wdata,
    output logic              run,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam ld_state_t LD_AFTER_LOAD = LD_CSUM;
    logic [7:0] csum;
`else
    localparam ld_state_t LD_AFTER_LOAD = LD_FIRE;
`endif

    ld_state_t         state;
    logic [15:0]       n;
    logic [15:0]       k;
    logic              xfer;
    logic              can_start;
    logic [15:0]       n_full;
    logic [ADDR_W-1:0] waddr;
    logic [63:0]       word;
    logic              word_ready;

    assign busy      = (state == LD_HDR0) || (state == LD_HDR1) ||
                       (state == LD_LOAD) || (state == LD_CSUM);
    assign in_ready  = busy;
    assign done      = (state == LD_DONE);
    assign err       = (state == LD_ERR);
    assign xfer      = in_valid && in_ready;
    assign can_start = start && ((state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERR));
    assign n_full    = {in_data, n[7:0]};
    // Word address wraps naturally at 2^ADDR_W.
    assign waddr     = ADDR_W'(BASE_ADDR) + ADDR_W'({k, 3'b000});

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (can_start),
        .en         (xfer && (state == LD_LOAD)),
        .din        (in_data),
        .word       (word),
        .word_ready (word_ready)
    );

    // Loader FSM with registered RAM write port and run strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LD_IDLE;
            n         <= 16'd0;
            k         <= 16'd0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 64'd0;
            run       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            ram_we <= 1'b0;
            run    <= 1'b0;
            case (state)
                LD_IDLE, LD_DONE, LD_ERR: begin
                    if (can_start) begin
                        state <= LD_HDR0;
                        n     <= 16'd0;
                        k     <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum  <= 8'd0;
`endif
                    end
                end
                LD_HDR0: begin
                    if (xfer) begin
                        n[7:0] <= in_data;
                        state  <= LD_HDR1;
                    end
                end
                LD_HDR1: begin
                    if (xfer) begin
                        n[15:8] <= in_data;
                        if (n_full > 16'(MAX_WORDS))
                            state <= LD_ERR;
                        else if (n_full == 16'd0)
                            state <= LD_AFTER_LOAD;
                        else
                            state <= LD_LOAD;
                    end
                end
                LD_LOAD: begin
                    if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (word_ready) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= waddr;
                            ram_wdata <= word;
                            k         <= k + 16'd1;
                            if (k == n - 16'd1)
                                state <= LD_AFTER_LOAD;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                LD_CSUM: begin
                    if (xfer)
                        state <= (in_data == csum) ? LD_FIRE : LD_ERR;
                end
`endif
                LD_FIRE: begin
                    run   <= 1'b1;
                    state <= LD_DONE;
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [63:0] ram_wdata;
    logic        run;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    int cyc         = 0;
    int wr_total    = 0;
    int run_total   = 0;
    int drop_total  = 0;
    int last_wr_cyc = 0;
    int last_run_cyc = 0;
    logic [15:0] wr_addr [64];
    logic [63:0] wr_data [64];

    localparam logic [63:0] W0 = 64'h0807060504030201;
    localparam logic [63:0] W1 = 64'h100F0E0D0C0B0A09;

    prog_loader #(.ADDR_W(16), .BASE_ADDR(0), .MAX_WORDS(8192)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .run       (run),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Write/run/ready observer sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            wr_addr[wr_total % 64] <= ram_addr;
            wr_data[wr_total % 64] <= ram_wdata;
            wr_total    <= wr_total + 1;
            last_wr_cyc <= cyc;
        end
        if (run) begin
            run_total    <= run_total + 1;
            last_run_cyc <= cyc;
        end
        if (busy && !in_ready)
            drop_total <= drop_total + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            checks++; failures++;
            $display("FAIL send_timeout byte=%02h in_ready=%b required=1", b, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_payload(input int first, input int count, input bit gap);
        for (int i = 0; i < count; i++)
            send_byte(8'(first + i), gap);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        checks++; if (ram_addr !== 16'h0) begin failures++; $display("FAIL reset_ram_addr got=%h exp=0000", ram_addr); end
        checks++; if (ram_wdata !== 64'h0) begin failures++; $display("FAIL reset_ram_wdata got=%h exp=0", ram_wdata); end
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL reset_run got=%b exp=0", run); end
        checks++; if ({busy, done, err, in_ready} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, err, in_ready}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy, in_ready} !== 2'b00) begin failures++; $display("FAIL idle_no_ready got=%b exp=00", {busy, in_ready}); end
    endtask

    task automatic check_two_words(input string tag, input int bw, input int br);
        checks++; if (wr_total - bw !== 2) begin failures++; $display("FAIL %s_wr_count got=%0d exp=2", tag, wr_total - bw); end
        checks++; if (wr_addr[bw % 64] !== 16'h0000) begin failures++; $display("FAIL %s_addr0 got=%h exp=0000", tag, wr_addr[bw % 64]); end
        checks++; if (wr_data[bw % 64] !== W0) begin failures++; $display("FAIL %s_data0 got=%h exp=%h", tag, wr_data[bw % 64], W0); end
        checks++; if (wr_addr[(bw + 1) % 64] !== 16'h0008) begin failures++; $display("FAIL %s_addr1 got=%h exp=0008", tag, wr_addr[(bw + 1) % 64]); end
        checks++; if (wr_data[(bw + 1) % 64] !== W1) begin failures++; $display("FAIL %s_data1 got=%h exp=%h", tag, wr_data[(bw + 1) % 64], W1); end
        checks++; if (run_total - br !== 1) begin failures++; $display("FAIL %s_run_count got=%0d exp=1", tag, run_total - br); end
        checks++; if (!(last_run_cyc > last_wr_cyc)) begin failures++; $display("FAIL %s_run_after_write run_cyc=%0d wr_cyc=%0d exp run later", tag, last_run_cyc, last_wr_cyc); end
        checks++; if ({done, err, busy} !== 3'b100) begin failures++; $display("FAIL %s_final_flags got=%b exp=100", tag, {done, err, busy}); end
    endtask

    task automatic send_image(input bit gap);
        send_byte(8'h02, gap);
        send_byte(8'h00, gap);
        send_payload(1, 16, gap);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h10, gap);
`endif
    endtask

    task automatic test_basic();
        int bw, br;
        apply_reset();
        #1; bw = wr_total; br = run_total;
        do_start();
        checks++; if ({busy, in_ready} !== 2'b11) begin failures++; $display("FAIL start_hdr0 got=%b exp=11", {busy, in_ready}); end
        send_image(1'b0);
        wait_done();
        check_two_words("basic", bw, br);
    endtask

    task automatic test_back_to_back_gapped();
        int bw, br, bd;
        #1; bw = wr_total; br = run_total; bd = drop_total;
        do_start();
        checks++; if ({done, busy} !== 2'b01) begin failures++; $display("FAIL restart_from_done got=%b exp=01", {done, busy}); end
        send_image(1'b1);
        wait_done();
        check_two_words("gapped", bw, br);
        checks++; if (drop_total !== bd) begin failures++; $display("FAIL gapped_ready_drop got=%0d exp=%0d", drop_total, bd); end
    endtask

    task automatic test_zero_words();
        int bw;
        apply_reset();
        #1; bw = wr_total;
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        checks++; if ({run, done, busy} !== 3'b000) begin failures++; $display("FAIL zero_fire got=%b exp=000", {run, done, busy}); end
        @(negedge clk);
        checks++; if ({run, done} !== 2'b11) begin failures++; $display("FAIL zero_run_pulse got=%b exp=11", {run, done}); end
        @(negedge clk);
        checks++; if ({run, done} !== 2'b01) begin failures++; $display("FAIL zero_run_end got=%b exp=01", {run, done}); end
        #1;
        checks++; if (wr_total !== bw) begin failures++; $display("FAIL zero_no_write got=%0d exp=%0d", wr_total - bw, 0); end
    endtask

    task automatic test_overflow();
        int bw, br;
        apply_reset();
        #1; bw = wr_total; br = run_total;
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0);
        checks++; if ({err, in_ready, busy} !== 3'b100) begin failures++; $display("FAIL ovf_err got=%b exp=100", {err, in_ready, busy}); end
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if ({wr_total - bw, run_total - br} !== {32'd0, 32'd0}) begin failures++; $display("FAIL ovf_no_activity wr=%0d run=%0d exp 0 0", wr_total - bw, run_total - br); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ovf_err_hold got=%b exp=1", err); end
        do_start();
        checks++; if ({busy, err, in_ready} !== 3'b101) begin failures++; $display("FAIL ovf_recover got=%b exp=101", {busy, err, in_ready}); end
    endtask

    task automatic test_reset_midload();
        int bw, br;
        apply_reset();
        do_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_payload(1, 5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({ram_we, run, busy, done, err, in_ready} !== 6'b0) begin failures++; $display("FAIL midrst_flags got=%b exp=000000", {ram_we, run, busy, done, err, in_ready}); end
        checks++; if ({ram_addr, ram_wdata} !== 80'h0) begin failures++; $display("FAIL midrst_bus got=%h exp=0", {ram_addr, ram_wdata}); end
        rst = 1'b0;
        #1; bw = wr_total; br = run_total;
        in_valid = 1'b1; in_data = 8'h55;
        repeat (20) @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if ({wr_total - bw, run_total - br} !== {32'd0, 32'd0}) begin failures++; $display("FAIL midrst_quiet wr=%0d run=%0d exp 0 0", wr_total - bw, run_total - br); end
        bw = wr_total; br = run_total;
        do_start();
        send_image(1'b0);
        wait_done();
        check_two_words("after_rst", bw, br);
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int bw, br;
        apply_reset();
        #1; bw = wr_total; br = run_total;
        do_start();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_payload(1, 8, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL csum_wait_trailer got=%b exp=1", in_ready); end
        send_byte(8'h08, 1'b0);
        wait_done();
        checks++; if ({run_total - br, wr_total - bw} !== {32'd1, 32'd1}) begin failures++; $display("FAIL csum_good run=%0d wr=%0d exp 1 1", run_total - br, wr_total - bw); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL csum_good_done got=%b exp=1", done); end
        bw = wr_total; br = run_total;
        do_start();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_payload(1, 8, 1'b0);
        send_byte(8'h09, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        checks++; if ({err, done} !== 2'b10) begin failures++; $display("FAIL csum_bad_err got=%b exp=10", {err, done}); end
        checks++; if (run_total !== br) begin failures++; $display("FAIL csum_bad_no_run got=%0d exp=0", run_total - br); end
        checks++; if ({wr_addr[bw % 64], wr_data[bw % 64]} !== {16'h0000, W0} || wr_total - bw !== 1) begin failures++; $display("FAIL csum_bad_write addr=%h data=%h n=%0d exp 0000 %h 1", wr_addr[bw % 64], wr_data[bw % 64], wr_total - bw, W0); end
    endtask
`else
    task automatic test_single_word();
        int bw, br;
        apply_reset();
        #1; bw = wr_total; br = run_total;
        do_start();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_payload(1, 8, 1'b0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL single_no_trailer got=%b exp=0", in_ready); end
        wait_done();
        checks++; if ({run_total - br, wr_total - bw} !== {32'd1, 32'd1}) begin failures++; $display("FAIL single_counts run=%0d wr=%0d exp 1 1", run_total - br, wr_total - bw); end
        checks++; if (wr_data[bw % 64] !== W0) begin failures++; $display("FAIL single_data got=%h exp=%h", wr_data[bw % 64], W0); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", done); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_basic();
        test_back_to_back_gapped();
        test_zero_words();
        test_overflow();
        test_reset_midload();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`else
        test_single_word();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
